// File: rtl/frame_assembler_pkg.sv
// Shared types and constants for the frame assembler: read-side state encoding
// and frame-format constants (header size, fragment length marker).
package frame_assembler_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EID  = 3'd1,
        LEN  = 3'd2,
        DATA = 3'd3,
        GAP  = 3'd4
    } state_t;

    localparam logic [7:0] LEN_FRAGMENT        = 8'hFF;
    localparam int         FRAGMENT_DATA_BYTES = 255;
    localparam int         HDR_BYTES           = 3;

endpackage

// File: rtl/frame_assembler_if.sv
// Byte-in / frame-out bundle of the frame assembler. timeout_err exists only when
// FRAME_TIMEOUT_EN is defined; dbg_state mirrors the read-side FSM for observation.
interface frame_assembler_if;
    import frame_assembler_pkg::*;

    // rx_data_valid is a one-cycle strobe with no back-pressure. A head byte is
    // consumed on a cycle where frame_data_latch and out_frame_data_valid are both high.
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic [7:0] out_frame_data;
    logic       out_frame_data_valid;
    logic       out_frame_valid;
    logic       frame_data_latch;
    logic       overflow;
    logic       overflow_clear;
`ifdef FRAME_TIMEOUT_EN
    logic       timeout_err;
`endif
    state_t     dbg_state;

    modport master (
        output rx_data, rx_data_valid, frame_data_latch, overflow_clear,
        input  out_frame_data, out_frame_data_valid, out_frame_valid, overflow,
`ifdef FRAME_TIMEOUT_EN
        input  timeout_err,
`endif
        input  dbg_state
    );

    modport slave (
        input  rx_data, rx_data_valid, frame_data_latch, overflow_clear,
        output out_frame_data, out_frame_data_valid, out_frame_valid, overflow,
`ifdef FRAME_TIMEOUT_EN
        output timeout_err,
`endif
        output dbg_state
    );

endinterface

// File: rtl/frame_assembler_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO; the head byte is readable one
// cycle after it is written. Caller must not write when full unless also reading.
module frame_assembler_byte_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr_en,
    input  logic [7:0] i_wr_data,
    input  logic       i_rd_en,
    output logic [7:0] o_rd_data,
    output logic       o_full,
    output logic       o_empty
);
    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (i_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({i_wr_en, i_rd_en})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);

endmodule

// File: rtl/frame_assembler.sv
// Frame assembler: buffers UART bytes and cuts them into type/eid/len/data frames.
// Define FRAME_TIMEOUT_EN to abort frames starved for TIMEOUT_CYCLES cycles.
module frame_assembler
    import frame_assembler_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 4
`ifdef FRAME_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
    input logic               clk,
    input logic               rst,
    frame_assembler_if.slave  bus
);
    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_remaining;
    logic [7:0] w_remaining_nxt;
    logic       r_overflow;
    logic       w_full;
    logic       w_empty;
    logic [7:0] w_head;
    logic       w_data_valid;
    logic       w_frame_valid;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;
    logic       w_expire;

    assign w_data_valid = !w_empty && (r_state != GAP);
    assign w_pop        = bus.frame_data_latch && w_data_valid;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign w_push       = bus.rx_data_valid && (!w_full || w_pop);
    assign w_drop       = bus.rx_data_valid && w_full && !w_pop;

    frame_assembler_byte_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_byte_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_push),
        .i_wr_data (bus.rx_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

`ifdef FRAME_TIMEOUT_EN
    logic [19:0] r_to_cnt;
    logic        r_timeout_err;
    logic        w_to_run;

    assign w_to_run = (r_state inside {EID, LEN, DATA}) && w_empty;
    assign w_expire = w_to_run && !w_push && (r_to_cnt == 20'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_to_cnt <= (!w_to_run || w_push || w_expire) ? '0 : r_to_cnt + 20'd1;
            if (w_expire)                r_timeout_err <= 1'b1;
            else if (bus.overflow_clear) r_timeout_err <= 1'b0;
        end
    end

    assign bus.timeout_err = r_timeout_err;
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_frame_valid   = 1'b1;
        case (r_state)
            IDLE: begin
                w_frame_valid = !w_empty;
                if (w_pop) w_state_nxt = EID;
            end
            EID: if (w_pop) w_state_nxt = LEN;
            LEN: begin
                if (w_pop) begin
                    w_remaining_nxt = (w_head == LEN_FRAGMENT) ? 8'(FRAGMENT_DATA_BYTES) : w_head;
                    w_state_nxt     = (w_head == 8'h00) ? GAP : DATA;
                end
            end
            DATA: begin
                if (w_pop) begin
                    w_remaining_nxt = r_remaining - 8'd1;
                    if (r_remaining == 8'd1) w_state_nxt = GAP;
                end
            end
            GAP: begin
                w_frame_valid = 1'b0;
                w_state_nxt   = IDLE;
            end
            default: begin
                w_frame_valid = 1'b0;
                w_state_nxt   = IDLE;
            end
        endcase
        // Starvation abort: the FIFO is empty here, so no pop can compete with it.
        if (w_expire) begin
            w_state_nxt     = GAP;
            w_remaining_nxt = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_remaining <= 8'd0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            if (w_drop)                  r_overflow <= 1'b1;
            else if (bus.overflow_clear) r_overflow <= 1'b0;
        end
    end

    assign bus.out_frame_data       = w_empty ? 8'h00 : w_head;
    assign bus.out_frame_data_valid = w_data_valid;
    assign bus.out_frame_valid      = w_frame_valid;
    assign bus.overflow             = r_overflow;
    assign bus.dbg_state            = r_state;

endmodule

// File: tb/tb_frame_assembler.sv
// Directed bench for frame_assembler; the timeout scenario is built only when
// FRAME_TIMEOUT_EN is defined (with TIMEOUT_CYCLES=16).
module tb_frame_assembler;
    import frame_assembler_pkg::*;

    logic clk;
    logic rst;
    frame_assembler_if bus ();

    frame_assembler #(
        .FIFO_DEPTH_LOG2 (4)
`ifdef FRAME_TIMEOUT_EN
        , .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus queue and per-cycle observation log (index = cycle number).
    logic [7:0] tx_q[$];
    logic       latch_on;
    logic       clr_on;
    int         cyc;
    logic       fv_trace[$];
    logic       dv_trace[$];
    state_t     st_trace[$];
    logic [7:0] pop_data[$];
    int         pop_cycle[$];

    task automatic clear_logs();
        cyc = 0;
        fv_trace.delete();
        dv_trace.delete();
        st_trace.delete();
        pop_data.delete();
        pop_cycle.delete();
    endtask

    // Samples outputs on the falling edge, then drives inputs for the next rising edge.
    task automatic step();
        @(negedge clk);
        fv_trace.push_back(bus.out_frame_valid);
        dv_trace.push_back(bus.out_frame_data_valid);
        st_trace.push_back(bus.dbg_state);
        if (latch_on && bus.out_frame_data_valid) begin
            pop_data.push_back(bus.out_frame_data);
            pop_cycle.push_back(cyc);
        end
        if (tx_q.size() > 0) begin
            bus.rx_data       = tx_q.pop_front();
            bus.rx_data_valid = 1'b1;
        end else begin
            bus.rx_data       = 8'h00;
            bus.rx_data_valid = 1'b0;
        end
        bus.frame_data_latch = latch_on;
        bus.overflow_clear   = clr_on;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst                  = 1'b1;
        tx_q.delete();
        latch_on             = 1'b0;
        clr_on               = 1'b0;
        bus.rx_data          = 8'h00;
        bus.rx_data_valid    = 1'b0;
        bus.frame_data_latch = 1'b0;
        bus.overflow_clear   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic check_idle_outputs(input string tag);
        n_checks++;
        if (bus.out_frame_valid !== 1'b0 || bus.out_frame_data_valid !== 1'b0 ||
            bus.out_frame_data !== 8'h00 || bus.overflow !== 1'b0 || bus.dbg_state !== IDLE) begin
            n_errors++;
            $display("FAIL %s: fv=%b dv=%b data=%h ovf=%b state=%0d, required 0 0 00 0 IDLE",
                     tag, bus.out_frame_valid, bus.out_frame_data_valid, bus.out_frame_data,
                     bus.overflow, bus.dbg_state);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        check_idle_outputs("reset_outputs");
`ifdef FRAME_TIMEOUT_EN
        n_checks++;
        if (bus.timeout_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_timeout_err: got %b required 0", bus.timeout_err);
        end
`endif
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp_d[$];
        int bad;
        int lp;
        apply_reset();
        exp_d = '{8'h01, 8'h42, 8'h02, 8'hAA, 8'hBB};
        foreach (exp_d[k]) tx_q.push_back(exp_d[k]);
        latch_on = 1'b1;
        run(12);
        n_checks++;
        if (pop_data.size() !== 5) begin
            n_errors++;
            $display("FAIL basic_pop_count: got %0d required 5", pop_data.size());
        end
        bad = 0;
        foreach (exp_d[k]) if (k >= pop_data.size() || pop_data[k] !== exp_d[k]) bad++;
        foreach (pop_cycle[k]) if (fv_trace[pop_cycle[k]] !== 1'b1) bad++;
        n_checks++;
        if (bad !== 0) begin
            n_errors++;
            $display("FAIL basic_data_order: %0d bad bytes/frame_valid, required 0", bad);
        end
        lp = (pop_cycle.size() > 0) ? pop_cycle[pop_cycle.size()-1] : 0;
        n_checks++;
        if (st_trace[lp+1] !== GAP || fv_trace[lp+1] !== 1'b0 || st_trace[lp+2] !== IDLE) begin
            n_errors++;
            $display("FAIL basic_gap: got state %0d fv %b then %0d, required GAP 0 then IDLE",
                     st_trace[lp+1], fv_trace[lp+1], st_trace[lp+2]);
        end
    endtask

    task automatic test_zero_length();
        int lp;
        apply_reset();
        tx_q = '{8'h01, 8'h42, 8'h00};
        latch_on = 1'b1;
        run(10);
        n_checks++;
        if (pop_data.size() !== 3 || pop_data[2] !== 8'h00) begin
            n_errors++;
            $display("FAIL zero_len_pops: got %0d pops required 3 ending in 00", pop_data.size());
        end
        lp = (pop_cycle.size() > 0) ? pop_cycle[pop_cycle.size()-1] : 0;
        n_checks++;
        if (fv_trace[lp+1] !== 1'b0 || st_trace[lp+1] !== GAP) begin
            n_errors++;
            $display("FAIL zero_len_gap: got fv %b state %0d after length, required 0 GAP",
                     fv_trace[lp+1], st_trace[lp+1]);
        end
    endtask

    task automatic test_fragment();
        int bad;
        int g;
        int before_gap;
        logic [7:0] tail[$];
        apply_reset();
        tx_q = '{8'h01, 8'h07, 8'hFF};
        for (int i = 0; i < 255; i++) tx_q.push_back(8'(i));
        tail = '{8'h02, 8'h08, 8'h01, 8'h55};
        foreach (tail[k]) tx_q.push_back(tail[k]);
        latch_on = 1'b1;
        run(275);
        n_checks++;
        if (pop_data.size() !== 262) begin
            n_errors++;
            $display("FAIL frag_total_pops: got %0d required 262", pop_data.size());
        end
        bad = 0;
        for (int k = 0; k < 255; k++) if (3 + k >= pop_data.size() || pop_data[3+k] !== 8'(k)) bad++;
        n_checks++;
        if (bad !== 0) begin
            n_errors++;
            $display("FAIL frag_payload: %0d bad bytes, required 0", bad);
        end
        g = -1;
        foreach (st_trace[k]) if (g < 0 && st_trace[k] == GAP) g = k;
        before_gap = 0;
        foreach (pop_cycle[k]) if (pop_cycle[k] < g) before_gap++;
        n_checks++;
        if (g < 0 || before_gap !== 258) begin
            n_errors++;
            $display("FAIL frag_pops_before_gap: got %0d (gap at %0d) required 258", before_gap, g);
        end
        n_checks++;
        if (g < 0 || fv_trace[g] !== 1'b0 || fv_trace[g+1] !== 1'b1 || st_trace[g+1] !== IDLE) begin
            n_errors++;
            $display("FAIL frag_next_start: gap at %0d not followed by IDLE with frame_valid", g);
        end
        bad = 0;
        foreach (tail[k]) if (258 + k >= pop_data.size() || pop_data[258+k] !== tail[k]) bad++;
        n_checks++;
        if (bad !== 0) begin
            n_errors++;
            $display("FAIL frag_next_frame: %0d bad bytes, required 0", bad);
        end
    endtask

    task automatic test_overflow();
        int bad;
        apply_reset();
        for (int i = 0; i < 17; i++) tx_q.push_back(8'h10 + 8'(i));
        run(20);
        n_checks++;
        if (bus.overflow !== 1'b1 || bus.out_frame_data !== 8'h10) begin
            n_errors++;
            $display("FAIL ovf_set: got ovf %b head %h required 1 10", bus.overflow, bus.out_frame_data);
        end
        clr_on = 1'b1;
        step();
        clr_on = 1'b0;
        step();
        n_checks++;
        if (bus.overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_clear: got %b required 0", bus.overflow);
        end
        tx_q.push_back(8'h99);
        latch_on = 1'b1;
        step();
        latch_on = 1'b0;
        step();
        n_checks++;
        if (bus.overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_full_push_pop: got %b required 0", bus.overflow);
        end
        latch_on = 1'b1;
        run(20);
        n_checks++;
        if (pop_data.size() !== 17) begin
            n_errors++;
            $display("FAIL ovf_drain_count: got %0d required 17", pop_data.size());
        end
        bad = 0;
        for (int k = 0; k < 16; k++) if (k >= pop_data.size() || pop_data[k] !== 8'h10 + 8'(k)) bad++;
        if (pop_data.size() < 17 || pop_data[16] !== 8'h99) bad++;
        n_checks++;
        if (bad !== 0 || bus.overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_drain_data: %0d bad bytes ovf %b, required 0 0", bad, bus.overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d[$];
        int bad;
        int p3;
        apply_reset();
        exp_d = '{8'h01, 8'h01, 8'h01, 8'h11, 8'h01, 8'h02, 8'h01, 8'h22};
        foreach (exp_d[k]) tx_q.push_back(exp_d[k]);
        run(10);
        latch_on = 1'b1;
        run(14);
        bad = 0;
        foreach (exp_d[k]) if (k >= pop_data.size() || pop_data[k] !== exp_d[k]) bad++;
        n_checks++;
        if (pop_data.size() !== 8 || bad !== 0) begin
            n_errors++;
            $display("FAIL b2b_data: got %0d pops %0d bad, required 8 0", pop_data.size(), bad);
        end
        if (pop_cycle.size() < 8) begin
            n_checks++;
            n_errors++;
            $display("FAIL b2b_gap: got %0d pops required 8", pop_cycle.size());
        end else begin
            p3 = pop_cycle[3];
            n_checks++;
            if (pop_cycle[3] - pop_cycle[0] !== 3 || pop_cycle[4] - p3 !== 2) begin
                n_errors++;
                $display("FAIL b2b_gap: got spacing %0d/%0d required 3/2",
                         pop_cycle[3] - pop_cycle[0], pop_cycle[4] - p3);
            end
            n_checks++;
            if (fv_trace[p3+1] !== 1'b0 || dv_trace[p3+1] !== 1'b0 || fv_trace[p3+2] !== 1'b1) begin
                n_errors++;
                $display("FAIL b2b_gap_signals: got fv %b dv %b next fv %b required 0 0 1",
                         fv_trace[p3+1], dv_trace[p3+1], fv_trace[p3+2]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        tx_q = '{8'h01, 8'h42, 8'h05, 8'hAA, 8'hBB};
        latch_on = 1'b1;
        run(4);
        apply_reset();
        check_idle_outputs("midframe_reset");
        tx_q = '{8'h01, 8'h43, 8'h00};
        latch_on = 1'b1;
        run(8);
        n_checks++;
        if (pop_data.size() !== 3 || pop_data[0] !== 8'h01 || pop_data[1] !== 8'h43) begin
            n_errors++;
            $display("FAIL midframe_next: got %0d pops required 3 starting 01 43", pop_data.size());
        end
    endtask

`ifdef FRAME_TIMEOUT_EN
    task automatic test_timeout();
        int p;
        int n_data;
        apply_reset();
        tx_q = '{8'h01, 8'h42, 8'h05, 8'hAA};
        latch_on = 1'b1;
        run(25);
        p = (pop_cycle.size() == 4) ? pop_cycle[3] : 0;
        n_data = 0;
        for (int k = p + 1; k < cyc && st_trace[k] == DATA; k++) n_data++;
        n_checks++;
        if (pop_cycle.size() !== 4 || n_data !== 16 || st_trace[p+17] !== GAP) begin
            n_errors++;
            $display("FAIL timeout_len: got %0d starved cycles required 16 then GAP", n_data);
        end
        n_checks++;
        if (bus.timeout_err !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_err_set: got %b required 1", bus.timeout_err);
        end
        clear_logs();
        tx_q = '{8'h01, 8'h43, 8'h00};
        run(8);
        n_checks++;
        if (pop_data.size() !== 3 || pop_data[1] !== 8'h43 || st_trace[pop_cycle[2]+1] !== GAP) begin
            n_errors++;
            $display("FAIL timeout_next_frame: got %0d pops required 3", pop_data.size());
        end
        clr_on = 1'b1;
        step();
        clr_on = 1'b0;
        step();
        n_checks++;
        if (bus.timeout_err !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_err_clear: got %b required 0", bus.timeout_err);
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        test_reset();
        test_basic_frame();
        test_zero_length();
        test_fragment();
        test_overflow();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef FRAME_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
